commit_trace_buffer: RTL and testbench
======================================

COMMIT_TRACE_BUFFER -- requirements
Module: commit_trace_buffer

Interface
REQ-001 Parameters: XLEN, 32, PC/data width.
REQ-002 Parameters: DEPTH, 16, trace entries; SHALL be a power of two and >=4.
REQ-003 Parameters: POST, 8, entries kept after trigger in mode 2; SHALL be in 1..DEPTH.
REQ-004 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-005 clock  in  1  rising-edge clock.
REQ-006 reset  in  1  asynchronous active-low reset.
REQ-007 arm  in  1  pulse; starts a capture session.
REQ-008 stop  in  1  pulse; ends the session.
REQ-009 mode  in  2  0=wrap, 1=stop-on-full, 2=PC-trigger; sampled on arm.
REQ-010 trig_pc  in  XLEN  trigger address; sampled on arm.
REQ-011 c_valid  in  1  one instruction committed this cycle.
REQ-012 c_pc  in  XLEN  committed PC.
REQ-013 c_instr  in  32  committed instruction word.
REQ-014 c_rd  in  5  destination register.
REQ-015 c_we  in  1  register write enable.
REQ-016 c_wdata  in  XLEN  write-back data.
REQ-017 r_valid  out  1  oldest entry available.
REQ-018 r_ready  in  1  consumer accepts oldest entry.
REQ-019 r_pc, r_instr, r_rd, r_we, r_wdata  out  as c_*  fields of oldest entry.
REQ-020 r_stamp  out  32  cycle stamp of oldest entry.
REQ-021 count  out  clog2(DEPTH)+1  valid entries.
REQ-022 full, overflow, triggered  out  1 each  status flags.
REQ-023 state  out  2  FSM state.

Function
REQ-024 FSM states SHALL be IDLE=0, ARMED=1, CAPTURE=2, DONE=3.
REQ-025 arm in any state SHALL clear count, pointers, overflow, triggered, stamp counter and go to ARMED if mode=2, else CAPTURE; arm has priority over stop and over a same-cycle commit (commit dropped).
REQ-026 stop in ARMED/CAPTURE SHALL go to DONE next edge; a same-cycle commit is still written; stop in IDLE/DONE ignored.
REQ-027 In ARMED/CAPTURE each c_valid SHALL write one entry at tail on that edge; visible on r_* the next cycle (1-cycle latency).
REQ-028 Stamp counter: 32-bit, increments every cycle after arm, wraps 2^32-1 -> 0; entry stamp = counter value in write cycle (0 for first cycle after arm).
REQ-029 Mode 0, write when full: overwrite oldest, advance head, count stays DEPTH, overflow sticky 1.
REQ-030 Mode 1, write when full: entry dropped, overflow=1, -> DONE.
REQ-031 Mode 2 ARMED: commits written with mode-0 wrap; c_valid with c_pc==trig_pc SHALL be written, set triggered, load post-counter POST-1, -> CAPTURE (DONE directly if POST=1).
REQ-032 Mode 2 CAPTURE: wrap writes; each write decrements post-counter; write at post-counter 0 -> DONE.
REQ-033 DONE: no writes; -> IDLE on edge where count becomes or is 0.
REQ-034 Readout first-word-fall-through in every state: r_valid = (count!=0); r_* driven combinationally from head; pop on r_valid & r_ready.
REQ-035 Pop on empty SHALL be ignored; count never exceeds DEPTH.
REQ-036 Simultaneous push and pop: count unchanged; when full, pop frees the slot and no overflow is flagged.
REQ-037 full = (count==DEPTH); pointers wrap modulo DEPTH.

Reset
REQ-038 On reset low: state IDLE, count 0, all flags 0, stamp 0, r_valid 0; storage array not reset.
REQ-039 Reset mid-session SHALL discard all entries; first legal arm after release starts cleanly.

Structure
REQ-040 Package trace_pkg SHALL hold state encoding, mode constants and the entry record (pc, instr, rd, we, wdata, stamp).
REQ-041 Storage SHALL be sub-module trace_ram: DEPTH x entry, one synchronous write port, one asynchronous read port.

Verification
REQ-042 Mode 0, DEPTH=16, arm, 5 commits (pc 0,4,8,12,16; x1=10,x2=3,x3=13,x4=7,x5=5), stop -> count=5, drain order pc 0..16 with those rd/wdata, stamps strictly increasing, then state IDLE.
REQ-043 Mode 0, 20 commits pc 0..76 -> count=16, overflow=1, first drained pc=16, last pc=76.
REQ-044 Mode 1, 17 commits -> 16 stored, pc 64 dropped, overflow=1, state DONE same edge.
REQ-045 Mode 2, trig_pc=40, POST=4, commits pc 0..80 -> triggered=1, DONE after pc 52, 14 entries pc 0..52, drain ends at pc 52.
REQ-046 Full buffer with push and pop every cycle for 10 cycles -> count stays 16, overflow stays 0, output order monotone.
REQ-047 Reset low mid-capture at count=7 -> count=0, r_valid=0, state IDLE immediately (asynchronous), no spurious pop after release.

Source files
------------

// File: rtl/trace_pkg.sv
// trace_pkg: shared definitions for the commit trace buffer.
//   - trace_state_t : capture FSM encoding (also exported on the state port)
//   - MODE_*        : capture mode codes sampled on arm
//   - trace_entry_t : one stored commit record (pc, instr, rd, we, wdata, stamp)
package trace_pkg;

  // Entries store fields at this width. The top casts at its boundary.
  localparam int TRACE_XLEN = 32;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } trace_state_t;

  localparam logic [1:0] MODE_WRAP      = 2'd0;
  localparam logic [1:0] MODE_STOP_FULL = 2'd1;
  localparam logic [1:0] MODE_PC_TRIG   = 2'd2;

  typedef struct packed {
    logic [TRACE_XLEN-1:0] pc;
    logic [31:0]           instr;
    logic [4:0]            rd;
    logic                  we;
    logic [TRACE_XLEN-1:0] wdata;
    logic [31:0]           stamp;
  } trace_entry_t;

  localparam int ENTRY_W = $bits(trace_entry_t);

endpackage

// File: rtl/trace_ram.sv
// trace_ram: DEPTH x entry storage for the commit trace buffer.
//   clock  : write clock
//   we     : write enable, waddr/wdata written on the rising edge
//   raddr  : asynchronous read address, rdata follows it combinationally
// The array is intentionally not reset; occupancy is tracked by the owner.
module trace_ram
  import trace_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic               clock,
  input  logic               we,
  input  logic [AW-1:0]      waddr,
  input  logic [ENTRY_W-1:0] wdata,
  input  logic [AW-1:0]      raddr,
  output logic [ENTRY_W-1:0] rdata
);

  logic [ENTRY_W-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/commit_trace_buffer.sv
// commit_trace_buffer: captures retired-instruction records into a circular
// buffer and presents them first-word-fall-through to a consumer.
//   clock, reset(active-low async)
//   arm/stop       : session control pulses; mode/trig_pc sampled on arm
//   c_*            : commit stream (one record per c_valid cycle)
//   r_* / r_ready  : FWFT readout of the oldest entry
//   count, full, overflow, triggered, state : status
//
// state      | meaning
// -----------+--------------------------------------------------------
// IDLE   (0) | no session; stored entries may still be drained
// ARMED  (1) | PC-trigger mode, wrapping until c_pc matches trig_pc
// CAPTURE(2) | recording commits (post-trigger window in PC-trigger mode)
// DONE   (3) | no more writes; returns to IDLE once the buffer is empty
module commit_trace_buffer #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 16,
  parameter int POST  = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     arm,
  input  logic                     stop,
  input  logic [1:0]               mode,
  input  logic [XLEN-1:0]          trig_pc,
  input  logic                     c_valid,
  input  logic [XLEN-1:0]          c_pc,
  input  logic [31:0]              c_instr,
  input  logic [4:0]               c_rd,
  input  logic                     c_we,
  input  logic [XLEN-1:0]          c_wdata,
  output logic                     r_valid,
  input  logic                     r_ready,
  output logic [XLEN-1:0]          r_pc,
  output logic [31:0]              r_instr,
  output logic [4:0]               r_rd,
  output logic                     r_we,
  output logic [XLEN-1:0]          r_wdata,
  output logic [31:0]              r_stamp,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     overflow,
  output logic                     triggered,
  output logic [1:0]               state
);
  import trace_pkg::*;

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  trace_state_t    st_q, st_d;
  logic [AW-1:0]   head_q, tail_q;
  logic [CW-1:0]   count_q, post_q;
  logic [31:0]     stamp_q;
  logic [1:0]      mode_q;
  logic [XLEN-1:0] trig_q;
  logic            ovf_q, trig_hit_q;

  logic do_push, do_pop, set_ovf, set_trig, load_post, dec_post;
  trace_entry_t wr_entry, rd_entry;

  assign full = (count_q == DEPTH_C);

  always_comb begin
    st_d      = st_q;
    do_push   = 1'b0;
    do_pop    = (count_q != '0) && r_ready;
    set_ovf   = 1'b0;
    set_trig  = 1'b0;
    load_post = 1'b0;
    dec_post  = 1'b0;
    if (arm) begin
      do_pop = 1'b0;
      st_d   = (mode == MODE_PC_TRIG) ? ST_ARMED : ST_CAPTURE;
    end else begin
      case (st_q)
        ST_ARMED, ST_CAPTURE: begin
          if (c_valid) begin
            // A same-cycle pop frees the slot, so only a full buffer with
            // no pop counts as overflow.
            if (full && !do_pop && mode_q == MODE_STOP_FULL) begin
              set_ovf = 1'b1;
              st_d    = ST_DONE;
            end else begin
              do_push = 1'b1;
              if (full && !do_pop) set_ovf = 1'b1;
              if (mode_q == MODE_PC_TRIG) begin
                if (st_q == ST_ARMED) begin
                  if (c_pc == trig_q) begin
                    set_trig  = 1'b1;
                    load_post = 1'b1;
                    st_d      = (POST == 1) ? ST_DONE : ST_CAPTURE;
                  end
                end else begin
                  // post_q counts writes still owed after the trigger entry
                  dec_post = 1'b1;
                  if (post_q <= CW'(1)) st_d = ST_DONE;
                end
              end
            end
          end
          if (stop) st_d = ST_DONE;
        end
        ST_DONE: begin
          if (count_q == '0 || (count_q == CW'(1) && do_pop)) st_d = ST_IDLE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      st_q       <= ST_IDLE;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      post_q     <= '0;
      stamp_q    <= '0;
      mode_q     <= MODE_WRAP;
      trig_q     <= '0;
      ovf_q      <= 1'b0;
      trig_hit_q <= 1'b0;
    end else begin
      st_q <= st_d;
      if (arm) begin
        head_q     <= '0;
        tail_q     <= '0;
        count_q    <= '0;
        post_q     <= '0;
        stamp_q    <= '0;
        mode_q     <= mode;
        trig_q     <= trig_pc;
        ovf_q      <= 1'b0;
        trig_hit_q <= 1'b0;
      end else begin
        stamp_q <= stamp_q + 32'd1;
        if (do_push) tail_q <= tail_q + 1'b1;
        // Overwriting a full buffer retires the oldest entry as well.
        if (do_pop || (do_push && full)) head_q <= head_q + 1'b1;
        if (do_push && !do_pop && !full) count_q <= count_q + 1'b1;
        else if (do_pop && !do_push)     count_q <= count_q - 1'b1;
        if (set_ovf)  ovf_q      <= 1'b1;
        if (set_trig) trig_hit_q <= 1'b1;
        if (load_post)     post_q <= CW'(POST - 1);
        else if (dec_post) post_q <= post_q - 1'b1;
      end
    end
  end

  always_comb begin
    wr_entry.pc    = TRACE_XLEN'(c_pc);
    wr_entry.instr = c_instr;
    wr_entry.rd    = c_rd;
    wr_entry.we    = c_we;
    wr_entry.wdata = TRACE_XLEN'(c_wdata);
    wr_entry.stamp = stamp_q;
  end

  trace_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clock (clock),
    .we    (do_push),
    .waddr (tail_q),
    .wdata (wr_entry),
    .raddr (head_q),
    .rdata (rd_entry)
  );

  assign r_valid   = (count_q != '0);
  assign r_pc      = XLEN'(rd_entry.pc);
  assign r_instr   = rd_entry.instr;
  assign r_rd      = rd_entry.rd;
  assign r_we      = rd_entry.we;
  assign r_wdata   = XLEN'(rd_entry.wdata);
  assign r_stamp   = rd_entry.stamp;
  assign count     = count_q;
  assign overflow  = ovf_q;
  assign triggered = trig_hit_q;
  assign state     = st_q;

endmodule

// File: tb/tb_commit_trace_buffer.sv
module tb_commit_trace_buffer;
  localparam int XLEN  = 32;
  localparam int DEPTH = 16;
  localparam int POST  = 4;

  logic        clock = 1'b0, reset = 1'b0, arm = 1'b0, stop = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [31:0] trig_pc = '0;
  logic        c_valid = 1'b0, c_we = 1'b0, r_ready = 1'b0;
  logic [31:0] c_pc = '0, c_instr = '0, c_wdata = '0;
  logic [4:0]  c_rd = '0;
  logic        r_valid, r_we, full, overflow, triggered;
  logic [31:0] r_pc, r_instr, r_wdata, r_stamp;
  logic [4:0]  r_rd;
  logic [4:0]  count;
  logic [1:0]  state;

  commit_trace_buffer #(.XLEN(XLEN), .DEPTH(DEPTH), .POST(POST)) dut (
    .clock(clock), .reset(reset), .arm(arm), .stop(stop), .mode(mode),
    .trig_pc(trig_pc), .c_valid(c_valid), .c_pc(c_pc), .c_instr(c_instr),
    .c_rd(c_rd), .c_we(c_we), .c_wdata(c_wdata), .r_valid(r_valid),
    .r_ready(r_ready), .r_pc(r_pc), .r_instr(r_instr), .r_rd(r_rd),
    .r_we(r_we), .r_wdata(r_wdata), .r_stamp(r_stamp), .count(count),
    .full(full), .overflow(overflow), .triggered(triggered), .state(state)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_err    = 0;
  bit chk_en   = 1'b0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Reference model: a queue of records plus session status.
  typedef struct {
    logic [31:0] pc, instr, wdata, stamp;
    logic [4:0]  rd;
    logic        we;
  } ent_t;

  ent_t        mq[$];
  int          mstate = 0;
  logic [1:0]  mmode  = 2'd0;
  logic [31:0] mtrig  = '0;
  logic [31:0] mstamp = '0;
  int          mrem   = 0;
  bit          movf   = 1'b0;
  bit          mtrg   = 1'b0;

  task automatic model_clear();
    mq.delete();
    mstate = 0; mstamp = '0; movf = 1'b0; mtrg = 1'b0; mrem = 0;
  endtask

  task automatic model_edge();
    ent_t e;
    int   nxt;
    bit   push;
    bit   active;
    if (arm) begin
      mq.delete();
      movf = 1'b0; mtrg = 1'b0; mstamp = '0; mrem = 0;
      mmode = mode; mtrig = trig_pc;
      mstate = (mode == 2'd2) ? 1 : 2;
      return;
    end
    active = (mstate == 1 || mstate == 2);
    nxt = mstate;
    if (r_ready && mq.size() > 0) void'(mq.pop_front());
    push = active && c_valid;
    if (push && mq.size() == DEPTH) begin
      movf = 1'b1;
      if (mmode == 2'd1) begin
        push = 1'b0;
        nxt  = 3;
      end else begin
        void'(mq.pop_front());
      end
    end
    if (push) begin
      e.pc = c_pc; e.instr = c_instr; e.rd = c_rd; e.we = c_we;
      e.wdata = c_wdata; e.stamp = mstamp;
      mq.push_back(e);
      if (mmode == 2'd2) begin
        if (mstate == 1) begin
          if (c_pc == mtrig) begin
            mtrg = 1'b1;
            mrem = POST - 1;
            nxt  = (mrem == 0) ? 3 : 2;
          end
        end else begin
          mrem--;
          if (mrem <= 0) nxt = 3;
        end
      end
    end
    if (stop && active) nxt = 3;
    if (mstate == 3 && mq.size() == 0) nxt = 0;
    mstate = nxt;
    mstamp = mstamp + 32'd1;
  endtask

  always @(negedge reset) model_clear();

  always @(posedge clock) begin
    if (reset) model_edge();
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clock) begin
    if (chk_en) begin
      chk("r_valid", r_valid, mq.size() != 0);
      chk("count", count, mq.size());
      chk("full", full, mq.size() == DEPTH);
      chk("overflow", overflow, movf);
      chk("triggered", triggered, mtrg);
      chk("state", state, mstate);
      if (mq.size() != 0) begin
        chk("r_pc", r_pc, mq[0].pc);
        chk("r_instr", r_instr, mq[0].instr);
        chk("r_rd", r_rd, mq[0].rd);
        chk("r_we", r_we, mq[0].we);
        chk("r_wdata", r_wdata, mq[0].wdata);
        chk("r_stamp", r_stamp, mq[0].stamp);
      end
    end
  end

  logic [31:0] dpc[$], dwd[$], dst[$];
  logic [4:0]  drd[$];

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_arm(input logic [1:0] m, input logic [31:0] t);
    arm = 1'b1; mode = m; trig_pc = t;
    step();
    arm = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

  task automatic commit(input logic [31:0] pc, input logic [4:0] rd, input logic [31:0] wd);
    c_valid = 1'b1; c_pc = pc; c_instr = 32'h0000_0013 ^ (pc << 7);
    c_rd = rd; c_we = 1'b1; c_wdata = wd;
    step();
    c_valid = 1'b0;
  endtask

  task automatic drain();
    dpc.delete(); dwd.delete(); dst.delete(); drd.delete();
    r_ready = 1'b1;
    for (int i = 0; i < 40 && r_valid; i++) begin
      dpc.push_back(r_pc); dwd.push_back(r_wdata);
      dst.push_back(r_stamp); drd.push_back(r_rd);
      step();
    end
    r_ready = 1'b0;
    chk("drain_bound", r_valid, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] wd5[5];
    wd5[0] = 32'd10; wd5[1] = 32'd3; wd5[2] = 32'd13; wd5[3] = 32'd7; wd5[4] = 32'd5;

    step(); step();
    chk("rst_state_low", state, 2'd0);
    chk("rst_count_low", count, 0);
    chk("rst_rvalid_low", r_valid, 1'b0);
    reset = 1'b1;
    chk_en = 1'b1;
    step();
    do_stop();
    chk("stop_in_idle", state, 2'd0);

    // Mode 0: five commits, stop, drain in order.
    do_arm(2'd0, 32'd0);
    for (int i = 0; i < 5; i++) commit(32'(4 * i), 5'(i + 1), wd5[i]);
    do_stop();
    chk("m0_count", count, 5);
    chk("m0_state_done", state, 2'd3);
    drain();
    chk("m0_n", dpc.size(), 5);
    for (int i = 0; i < 5 && i < dpc.size(); i++) begin
      chk("m0_pc", dpc[i], 4 * i);
      chk("m0_rd", drd[i], i + 1);
      chk("m0_wdata", dwd[i], wd5[i]);
      if (i > 0) chk("m0_stamp_inc", dst[i] > dst[i-1], 1'b1);
    end
    if (dst.size() > 0) chk("m0_stamp0", dst[0], 0);
    chk("m0_idle", state, 2'd0);

    // Mode 0 wrap: 20 commits into 16 slots.
    do_arm(2'd0, 32'd0);
    for (int i = 0; i < 20; i++) commit(32'(4 * i), 5'(i % 32), 32'(i * 3));
    chk("wrap_count", count, 16);
    chk("wrap_ovf", overflow, 1'b1);
    do_stop();
    drain();
    chk("wrap_n", dpc.size(), 16);
    if (dpc.size() == 16) begin
      chk("wrap_first", dpc[0], 16);
      chk("wrap_last", dpc[15], 76);
    end

    // Mode 1: 17th commit dropped.
    do_arm(2'd1, 32'd0);
    for (int i = 0; i < 17; i++) begin
      commit(32'(4 * i), 5'd2, 32'(i));
      if (i == 15) chk("sof_full_capture", state, 2'd2);
    end
    chk("sof_state", state, 2'd3);
    chk("sof_count", count, 16);
    chk("sof_ovf", overflow, 1'b1);
    drain();
    chk("sof_n", dpc.size(), 16);
    if (dpc.size() == 16) chk("sof_last", dpc[15], 60);
    chk("sof_idle", state, 2'd0);

    // Mode 2: trigger on pc 40, four entries kept from trigger.
    do_arm(2'd2, 32'd40);
    chk("trg_armed", state, 2'd1);
    for (int i = 0; i <= 20; i++) begin
      commit(32'(4 * i), 5'd7, 32'(100 + i));
      if (i == 9)  chk("trg_pre", state, 2'd1);
      if (i == 10) chk("trg_hit", state, 2'd2);
      if (i == 12) chk("trg_window", state, 2'd2);
      if (i == 13) chk("trg_done_at_52", state, 2'd3);
    end
    chk("trg_flag", triggered, 1'b1);
    chk("trg_count", count, 14);
    chk("trg_ovf", overflow, 1'b0);
    drain();
    chk("trg_n", dpc.size(), 14);
    if (dpc.size() == 14) begin
      chk("trg_first", dpc[0], 0);
      chk("trg_last", dpc[13], 52);
    end

    // Full buffer, push and pop every cycle.
    do_arm(2'd0, 32'd0);
    for (int i = 0; i < 16; i++) commit(32'(4 * i), 5'd1, 32'(i));
    chk("pp_full", full, 1'b1);
    dpc.delete();
    r_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      dpc.push_back(r_pc);
      commit(32'(64 + 4 * i), 5'd1, 32'(i));
      chk("pp_count", count, 16);
      chk("pp_ovf", overflow, 1'b0);
    end
    r_ready = 1'b0;
    for (int i = 0; i < 10; i++) chk("pp_order", dpc[i], 4 * i);
    do_stop();
    drain();
    chk("pp_n", dpc.size(), 16);
    if (dpc.size() == 16) begin
      chk("pp_first", dpc[0], 40);
      chk("pp_last", dpc[15], 100);
    end

    // Asynchronous reset mid-capture.
    do_arm(2'd0, 32'd0);
    for (int i = 0; i < 7; i++) commit(32'(4 * i), 5'd3, 32'(i));
    chk("ar_count7", count, 7);
    #2 reset = 1'b0;
    #1;
    chk("ar_count", count, 0);
    chk("ar_rvalid", r_valid, 1'b0);
    chk("ar_state", state, 2'd0);
    step();
    reset = 1'b1;
    r_ready = 1'b1;
    step(); step();
    chk("ar_no_pop", count, 0);
    r_ready = 1'b0;

    // Arm beats a same-cycle commit; stop keeps a same-cycle commit.
    c_valid = 1'b1; c_pc = 32'h100; c_rd = 5'd9; c_we = 1'b0; c_wdata = 32'h55;
    arm = 1'b1; mode = 2'd0;
    step();
    arm = 1'b0; c_valid = 1'b0;
    chk("arm_drops_commit", count, 0);
    commit(32'h200, 5'd4, 32'hAA);
    commit(32'h204, 5'd5, 32'hBB);
    stop = 1'b1;
    commit(32'h208, 5'd6, 32'hCC);
    stop = 1'b0;
    chk("stop_keeps_commit", count, 3);
    chk("stop_done", state, 2'd3);
    drain();
    chk("post_rst_n", dpc.size(), 3);
    if (dpc.size() == 3) chk("post_rst_last", dpc[2], 32'h208);
    step();

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
